// File: rtl/sudoku_pkg.sv
// Shared Sudoku board definitions: dimensions, value limits and the read-stream FSM state type.
package sudoku_pkg;

  localparam int BOARD_DIM  = 9;
  localparam int CELL_COUNT = BOARD_DIM * BOARD_DIM;
  localparam int CELL_W     = 4;
  localparam int MAX_VALUE  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } stream_state_t;

  function automatic logic cell_is_bad(input logic [CELL_W-1:0] value);
    return value > CELL_W'(MAX_VALUE);
  endfunction

endpackage

// File: rtl/sudoku_cell_counter.sv
// Row-major row/column walker over the 9x9 board with clear, step and a last-cell flag.
module sudoku_cell_counter
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       last
);

  localparam logic [3:0] MAX_IDX = 4'(BOARD_DIM - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
    end
  end

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/sudoku_board_streamer.sv
// Walks all 81 board cells through the synchronous read port and emits them on a valid/ready byte stream.
// Define SUDOKU_STREAM_PACK_EN to pack two cells per byte (41 bytes) instead of {col, value} (81 bytes).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; address held at (0,0)
// ST_READ    | current cell address presented to the board
// ST_CAPTURE | board data latched into the output register
// ST_SEND    | out_valid high, holding until the sink accepts
// ST_DONE    | one-cycle done pulse, counter returns to (0,0)
module sudoku_board_streamer
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] rd_row,
  output logic [3:0] rd_col,
  input  logic [3:0] rd_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       bad_cell
);

  stream_state_t state, state_nxt;
  logic          cnt_clear;
  logic          cnt_step;
  logic          cnt_last;
  logic [7:0]    data_q;
  logic          bad_q;
`ifdef SUDOKU_STREAM_PACK_EN
  logic          odd_q;
`endif

  sudoku_cell_counter u_cell_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .step  (cnt_step),
    .row   (rd_row),
    .col   (rd_col),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (start) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
`ifdef SUDOKU_STREAM_PACK_EN
        // An even cell only fills the low nibble; fetch its partner unless it was cell 80.
        if (!odd_q && !cnt_last) begin
          cnt_step  = 1'b1;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_SEND;
        end
`else
        state_nxt = ST_SEND;
`endif
      end
      ST_SEND: begin
        if (out_ready) begin
          if (cnt_last) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_step  = 1'b1;
            state_nxt = ST_READ;
          end
        end
      end
      ST_DONE: begin
        cnt_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      bad_q  <= 1'b0;
`ifdef SUDOKU_STREAM_PACK_EN
      odd_q  <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && start) begin
        bad_q <= 1'b0;
`ifdef SUDOKU_STREAM_PACK_EN
        odd_q <= 1'b0;
`endif
      end
      if (state == ST_CAPTURE) begin
        if (cell_is_bad(rd_data)) bad_q <= 1'b1;
`ifdef SUDOKU_STREAM_PACK_EN
        if (!odd_q) begin
          data_q <= {4'h0, rd_data};
          if (!cnt_last) odd_q <= 1'b1;
        end else begin
          data_q[7:4] <= rd_data;
          odd_q       <= 1'b0;
        end
`else
        data_q <= {rd_col, rd_data};
`endif
      end
    end
  end

  assign out_data  = data_q;
  assign bad_cell  = bad_q;
  assign out_valid = (state == ST_SEND);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sudoku_board_streamer.sv
// Scoreboard bench for sudoku_board_streamer: a board model feeds the read port, expected bytes are queued per dump.
module tb_sudoku_board_streamer;

`ifdef SUDOKU_STREAM_PACK_EN
  localparam int N_BYTES    = 41;
  localparam int FIRST_LAT  = 4;
  localparam int DUMP_EDGES = 203;
`else
  localparam int N_BYTES    = 81;
  localparam int FIRST_LAT  = 2;
  localparam int DUMP_EDGES = 243;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] rd_row, rd_col, rd_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic       busy, done, bad_cell;

  logic [3:0] board [81];
  logic [7:0] exp_q [$];
  logic       exp_bad;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_acc    = 0;
  int         n_done   = 0;
  int         cyc      = 0;
  int         hs_cyc   = 0;
  logic       rand_ready = 1'b0;
  logic       ready_fix  = 1'b1;

  sudoku_board_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .bad_cell  (bad_cell)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Board storage with a one-cycle registered read port.
  always @(posedge clk) begin
    if (int'(rd_row) < 9 && int'(rd_col) < 9)
      rd_data <= board[int'(rd_row) * 9 + int'(rd_col)];
    else
      rd_data <= 4'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Every valid cycle must present the head of the queue; pop when the handshake will occur.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("byte", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_acc++;
          hs_cyc = cyc + 1;
        end
      end
    end
    if (rst_n && done) begin
      n_done++;
      chk("done_q_empty", 32'(exp_q.size()), 32'd0);
      chk("done_latency", 32'(cyc), 32'(hs_cyc));
    end
  end

  task automatic load_expected();
    logic [3:0] lo, hi;
    exp_q.delete();
    exp_bad = 1'b0;
    for (int n = 0; n < 81; n++)
      if (board[n] > 4'd9) exp_bad = 1'b1;
`ifdef SUDOKU_STREAM_PACK_EN
    for (int k = 0; k < 41; k++) begin
      lo = board[2 * k];
      hi = (2 * k + 1 < 81) ? board[2 * k + 1] : 4'h0;
      exp_q.push_back({hi, lo});
    end
`else
    for (int n = 0; n < 81; n++)
      exp_q.push_back({4'(n % 9), board[n]});
`endif
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_dump(input bit hold_start, input bit timing);
    int c, c2, d0;
    n_acc = 0;
    d0    = n_done;
    load_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("bad_clear_at_start", 32'(bad_cell), 32'd0);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (timing) chk("first_valid_lat", 32'(c), 32'(FIRST_LAT));
    wait_done(c2);
    if (timing) chk("dump_edges", 32'(c + c2), 32'(DUMP_EDGES));
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("bad_cell", 32'(bad_cell), 32'(exp_bad));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("rd_row_idle", 32'(rd_row), 32'd0);
    chk("rd_col_idle", 32'(rd_col), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bytes_accepted", 32'(n_acc), 32'(N_BYTES));
    chk("done_count", 32'(n_done - d0), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("bad_sticky", 32'(bad_cell), 32'(exp_bad));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 81; n++) board[n] = 4'((n % 9) + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bad_cell", 32'(bad_cell), 32'd0);
    chk("rst_rd_row", 32'(rd_row), 32'd0);
    chk("rst_rd_col", 32'(rd_col), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ready tied high: exact timing.
    run_dump(1'b0, 1'b1);

    // Random backpressure on the same board.
    rand_ready = 1'b1;
    run_dump(1'b0, 1'b0);
    rand_ready = 1'b0;

    // Out-of-range cell: flagged, transmitted unchanged, sticky after done.
    board[4 * 9 + 7] = 4'd12;
    run_dump(1'b0, 1'b1);
    for (int n = 0; n < 81; n++) board[n] = 4'((n % 9) + 1);
    run_dump(1'b0, 1'b1);

    // start held high for the whole dump and through the DONE cycle.
    run_dump(1'b1, 1'b1);

    // Reset while stalled in SEND on byte 20.
    n_acc = 0;
    load_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    while (n_acc < 20 && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    ready_fix = 1'b0;
    while (!(out_valid && !out_ready) && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("stalled_at_byte20", 32'(n_acc), 32'd20);
    d0    = n_done;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    rst_n     = 1'b1;
    ready_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);
    chk("rst_mid_rd_row", 32'(rd_row), 32'd0);
    chk("rst_mid_rd_col", 32'(rd_col), 32'd0);
    run_dump(1'b0, 1'b1);

    // Uniform board of fives.
    for (int n = 0; n < 81; n++) board[n] = 4'd5;
    run_dump(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
